// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared opcodes, field positions and control word
// for the reg_alu front end, decoder and future benches.
package reg_alu_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ALU = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h3;
  localparam logic [3:0] OP_SRL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_SLT = 4'h6;
  localparam logic [3:0] OP_RPT = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;

  // Field order matches the reg_alu input list.
  typedef struct packed {
    logic              slt_sel;
    logic              sel;
    logic              main_sel;
    logic              sft_sel;
    logic              ryt_sft_sel;
    logic              wr;
    logic [1:0]        op;
    logic [3:0]        sft_op;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_DECODE,
    S_IMM,
    S_REPEAT
  } state_t;

endpackage

// File: rtl/reg_alu_decode.sv
// reg_alu_decode: combinational opcode to control-word decoder.
// d_in is left 0; the sequencer fills it for LDI.
module reg_alu_decode
  import reg_alu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               is_issue,
  output logic               is_ldi,
  output logic               is_rpt,
  output logic               is_bad
);

  logic [3:0] opc;
  assign opc = instr[OPC_HI:OPC_LO];

  // Map each opcode to its control word and class flags.
  always_comb begin
    ctrl     = '0;
    is_issue = 1'b0;
    is_ldi   = 1'b0;
    is_rpt   = 1'b0;
    is_bad   = 1'b0;
    ctrl.rd_addr_a = instr[RA_HI:RA_LO];
    ctrl.rd_addr_b = instr[RB_HI:RB_LO];
    ctrl.wr_addr   = instr[RD_HI:RD_LO];
    unique case (1'b1)
      (opc == OP_NOP): ;
      (opc == OP_LDI): begin
        is_ldi        = 1'b1;
        ctrl.wr       = 1'b1;
        ctrl.main_sel = 1'b1;
      end
      (opc == OP_ALU): begin
        is_issue = 1'b1;
        ctrl.sel = 1'b1;
        ctrl.wr  = 1'b1;
        ctrl.op  = instr[1:0];
      end
      (opc == OP_SLL),
      (opc == OP_SRL),
      (opc == OP_SRA): begin
        is_issue         = 1'b1;
        ctrl.sel         = 1'b1;
        ctrl.main_sel    = 1'b1;
        ctrl.wr          = 1'b1;
        ctrl.sft_op      = instr[FN_HI:FN_LO];
        ctrl.sft_sel     = (opc != OP_SLL);
        ctrl.ryt_sft_sel = (opc == OP_SRA);
      end
      (opc == OP_SLT): begin
        is_issue         = 1'b1;
        ctrl.slt_sel     = 1'b1;
        ctrl.sel         = 1'b1;
        ctrl.sft_sel     = 1'b1;
        ctrl.ryt_sft_sel = 1'b1;
        ctrl.wr          = 1'b1;
      end
      (opc == OP_RPT): is_rpt = 1'b1;
      default: is_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer driving reg_alu controls,
// with two-beat LDI and a repeat prefix.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16,
  parameter int RPT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              slt_sel,
  output logic              sel,
  output logic              main_sel,
  output logic              sft_sel,
  output logic              ryt_sft_sel,
  output logic              wr,
  output logic [1:0]        op,
  output logic [3:0]        sft_op,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  output logic              issue,
  output logic              illegal,
  output logic [CNT_W-1:0]  icount
);

  state_t           state_q, state_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  ctrl_t            pend_q, pend_d;
  ctrl_t            out_q, out_d;
  logic             issue_q, issue_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t dec_ctrl;
  logic  dec_issue, dec_ldi, dec_rpt, dec_bad;
  logic  acc;

  reg_alu_decode u_dec (
    .instr    (instr),
    .ctrl     (dec_ctrl),
    .is_issue (dec_issue),
    .is_ldi   (dec_ldi),
    .is_rpt   (dec_rpt),
    .is_bad   (dec_bad)
  );

  assign instr_ready = reset & (state_q != S_REPEAT);
  assign acc = instr_valid & instr_ready;

  // Next state, repeat count and the control word to issue.
  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    pend_d  = pend_q;
    out_d   = '0;
    issue_d = 1'b0;
    ill_d   = ill_q;
    unique case (state_q)
      S_DECODE: begin
        if (acc) begin
          unique case (1'b1)
            dec_issue: begin
              out_d   = dec_ctrl;
              issue_d = 1'b1;
              if (rpt_q != '0) begin
                pend_d  = dec_ctrl;
                state_d = S_REPEAT;
              end
            end
            dec_ldi: begin
              pend_d  = dec_ctrl;
              state_d = S_IMM;
            end
            dec_rpt: rpt_d = RPT_W'(instr[FN_HI:FN_LO]);
            dec_bad: begin
              ill_d = 1'b1;
              rpt_d = '0;
            end
            default: rpt_d = '0;
          endcase
        end
      end
      S_IMM: begin
        if (acc) begin
          out_d      = pend_q;
          out_d.d_in = instr;
          issue_d    = 1'b1;
          pend_d     = out_d;
          state_d    = (rpt_q != '0) ? S_REPEAT : S_DECODE;
        end
      end
      S_REPEAT: begin
        out_d   = pend_q;
        issue_d = 1'b1;
        rpt_d   = rpt_q - RPT_W'(1);
        if (rpt_q == RPT_W'(1)) state_d = S_DECODE;
      end
      default: state_d = S_DECODE;
    endcase
    cnt_d = cnt_q + CNT_W'(issue_d);
  end

  // State and registered outputs; reset drops pending work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_DECODE;
      rpt_q   <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      issue_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rpt_q   <= rpt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      issue_q <= issue_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign slt_sel     = out_q.slt_sel;
  assign sel         = out_q.sel;
  assign main_sel    = out_q.main_sel;
  assign sft_sel     = out_q.sft_sel;
  assign ryt_sft_sel = out_q.ryt_sft_sel;
  assign wr          = out_q.wr;
  assign op          = out_q.op;
  assign sft_op      = out_q.sft_op;
  assign rd_addr_a   = out_q.rd_addr_a;
  assign rd_addr_b   = out_q.rd_addr_b;
  assign wr_addr     = out_q.wr_addr;
  assign d_in        = out_q.d_in;
  assign issue       = issue_q;
  assign illegal     = ill_q;
  assign icount      = cnt_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed vectors for the reg_alu sequencer,
// with hand-computed expected control words.
module tb_reg_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr;
  logic [1:0]  op;
  logic [3:0]  sft_op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in;
  logic        issue, illegal;
  logic [15:0] icount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_alu_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .slt_sel     (slt_sel),
    .sel         (sel),
    .main_sel    (main_sel),
    .sft_sel     (sft_sel),
    .ryt_sft_sel (ryt_sft_sel),
    .wr          (wr),
    .op          (op),
    .sft_op      (sft_op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .issue       (issue),
    .illegal     (illegal),
    .icount      (icount)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one word at the falling edge; outputs are sampled here too.
  task automatic step(input logic v, input logic [15:0] w);
    @(negedge clk);
    instr_valid = v;
    instr = w;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_issue", issue, 0);
    chk("rst_wr", wr, 0);
    chk("rst_icount", icount, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", instr_ready, 0);
    chk("rst_din", d_in, 0);
    reset = 1'b1;
    #1 chk("rel_ready", instr_ready, 1);

    // LDI r0, 0x03FF
    step(1, 16'h1000);
    step(1, 16'h03FF);
    step(0, 16'h0);
    chk("ldi_issue", issue, 1);
    chk("ldi_wr", wr, 1);
    chk("ldi_main", main_sel, 1);
    chk("ldi_sel", sel, 0);
    chk("ldi_waddr", wr_addr, 0);
    chk("ldi_din", d_in, 16'h03FF);
    chk("ldi_icount", icount, 1);
    step(0, 16'h0);
    chk("ldi_wr_off", wr, 0);
    chk("ldi_issue_off", issue, 0);
    chk("ldi_din_off", d_in, 0);

    // SLL r1, r2, 3
    step(1, 16'h3283);
    step(0, 16'h0);
    chk("sll_issue", issue, 1);
    chk("sll_ctl", {sel, main_sel, sft_sel, ryt_sft_sel}, 4'b1100);
    chk("sll_shamt", sft_op, 3);
    chk("sll_ra", rd_addr_a, 2);
    chk("sll_wa", wr_addr, 1);
    chk("sll_icount", icount, 2);

    // SLT r1, r7, r3
    step(1, 16'h63D8);
    step(0, 16'h0);
    chk("slt_ctl", {slt_sel, sel, main_sel, sft_sel, ryt_sft_sel},
        5'b11011);
    chk("slt_ra", rd_addr_a, 7);
    chk("slt_rb", rd_addr_b, 3);
    chk("slt_wa", wr_addr, 1);
    chk("slt_sftop", sft_op, 0);

    // ALU r1, r1, r2, op 3
    step(1, 16'h2253);
    step(0, 16'h0);
    chk("alu_ctl", {slt_sel, sel, main_sel, wr}, 4'b0101);
    chk("alu_op", op, 3);
    chk("alu_rb", rd_addr_b, 2);
    chk("alu_icount", icount, 4);

    // RPT 2 then SRA r1, r1, 1: three issues
    step(1, 16'hF002);
    step(1, 16'h5241);
    step(0, 16'h0);
    chk("rpt_i1", issue, 1);
    chk("rpt_ryt1", ryt_sft_sel, 1);
    chk("rpt_sft1", sft_op, 1);
    chk("rpt_rdy1", instr_ready, 0);
    step(0, 16'h0);
    chk("rpt_i2", issue, 1);
    chk("rpt_rdy2", instr_ready, 0);
    step(0, 16'h0);
    chk("rpt_i3", issue, 1);
    chk("rpt_ryt3", ryt_sft_sel, 1);
    chk("rpt_rdy3", instr_ready, 1);
    chk("rpt_icount", icount, 7);
    step(0, 16'h0);
    chk("rpt_i4", issue, 0);

    // Illegal word, then illegal clears an armed repeat
    step(1, 16'h9000);
    step(0, 16'h0);
    chk("ill_set", illegal, 1);
    chk("ill_noissue", issue, 0);
    step(1, 16'hF003);
    step(1, 16'hA000);
    step(1, 16'h3283);
    step(0, 16'h0);
    chk("ill_once_i1", issue, 1);
    chk("ill_sticky", illegal, 1);
    step(0, 16'h0);
    chk("ill_once_i2", issue, 0);
    chk("ill_icount", icount, 8);

    // Immediate that looks like an opcode is taken as data
    step(1, 16'h1A00);
    step(1, 16'hF00F);
    step(0, 16'h0);
    chk("imm_issue", issue, 1);
    chk("imm_din", d_in, 16'hF00F);
    chk("imm_wa", wr_addr, 5);
    step(0, 16'h0);
    chk("imm_rpt_none", issue, 0);

    // RPT then NOP consumes the count
    step(1, 16'hF001);
    step(1, 16'h0000);
    step(1, 16'h3283);
    step(0, 16'h0);
    chk("nop_i1", issue, 1);
    step(0, 16'h0);
    chk("nop_i2", issue, 0);
    chk("nop_icount", icount, 10);

    // RPT 1 then LDI: immediate held across both issues
    step(1, 16'hF001);
    step(1, 16'h1000);
    step(1, 16'h0055);
    step(0, 16'h0);
    chk("rldi_i1", issue, 1);
    chk("rldi_rdy1", instr_ready, 0);
    step(0, 16'h0);
    chk("rldi_i2", issue, 1);
    chk("rldi_din2", d_in, 16'h0055);
    chk("rldi_rdy2", instr_ready, 1);
    step(0, 16'h0);
    chk("rldi_i3", issue, 0);
    chk("rldi_icount", icount, 12);

    // Reset in the middle of a repeat burst
    step(1, 16'hF005);
    step(1, 16'h3283);
    step(0, 16'h0);
    chk("mrst_i1", issue, 1);
    #2 reset = 1'b0;
    #1;
    chk("mrst_issue", issue, 0);
    chk("mrst_wr", wr, 0);
    chk("mrst_icount", icount, 0);
    chk("mrst_sftop", sft_op, 0);
    chk("mrst_wa", wr_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mrst_ready", instr_ready, 1);
    step(0, 16'h0);
    chk("mrst_post1", issue, 0);
    step(0, 16'h0);
    chk("mrst_post2", issue, 0);
    chk("mrst_post_cnt", icount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
